// File: rtl/fifo_stream_reader_if.sv
// Bus bundle for fifo_stream_reader: the FIFO read port on one side and the
// outgoing valid/ready stream on the other.
//
// Stream handshake: a word moves from master to slave in every cycle where
// m_valid=1 and m_ready=1 at the rising clock edge. Once m_valid is raised,
// m_valid and m_data hold steady until that transfer happens. m_valid never
// depends on m_ready.
//
// FIFO read port: fifo_read=1 in cycle T pops one word; the FIFO presents it
// on fifo_data during cycle T+1. fifo_empty is a registered flag owned by the FIFO.
interface fifo_stream_reader_if #(
  parameter int WIDTH = 8
) ();

  logic             fifo_read;
  logic             fifo_empty;
  logic [WIDTH-1:0] fifo_data;
  logic             m_valid;
  logic             m_ready;
  logic [WIDTH-1:0] m_data;

  // The reader block: drives the read strobe and the stream.
  modport master (
    output fifo_read,
    input  fifo_empty,
    input  fifo_data,
    output m_valid,
    input  m_ready,
    output m_data
  );

  // The environment: the FIFO and the stream sink.
  modport slave (
    input  fifo_read,
    output fifo_empty,
    output fifo_data,
    input  m_valid,
    output m_ready,
    input  m_data
  );

endinterface

// File: rtl/fifo_stream_reader.sv
// fifo_stream_reader: pulls words out of a FIFO whose read data arrives one
// cycle after the strobe, and presents them as a registered valid/ready stream.
// A two-entry in-order buffer absorbs the read latency, so the block streams
// one word per cycle when the sink is always ready. It also stops reading early
// enough that a word already in flight always finds a free buffer slot.
module fifo_stream_reader #(
  parameter int WIDTH = 8,
  parameter int CNTW  = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_n_i,
  input  logic                 enable_i,
  fifo_stream_reader_if.master bus,
  output logic [CNTW-1:0]      xfer_count_o,
  output logic                 idle_o,
  output logic [1:0]           occ_state_o
);

  // Buffer occupancy doubles as the FSM state; buf0 is always the oldest word.
  typedef enum logic [1:0] {
    OCC_EMPTY = 2'd0,
    OCC_ONE   = 2'd1,
    OCC_TWO   = 2'd2
  } occ_e;

  occ_e             state_q, state_d;
  logic             inflight_q, inflight_d;
  logic [WIDTH-1:0] buf0_q, buf0_d;
  logic [WIDTH-1:0] buf1_q, buf1_d;
  logic [CNTW-1:0]  xfer_q, xfer_d;

  logic             pop;
  logic             capture;
  logic             rd;
  logic [2:0]       committed;

  // A word leaves when the sink takes it. A read issued last cycle delivers its data now.
  assign pop     = (state_q != OCC_EMPTY) && bus.m_ready;
  assign capture = inflight_q;

  // Slots committed at the end of this cycle without a new read:
  // held words plus the word in flight, minus the word being popped.
  always_comb begin
    committed = {1'b0, state_q} + {2'b00, inflight_q} - {2'b00, pop};
  end

  // Issue a read only if its data is sure to have a free slot one cycle later.
  // rst_n gates the strobe directly, so no read leaves during reset.
  assign rd = rst_n_i && enable_i && !bus.fifo_empty && (committed < 3'd2);

  // Next occupancy, buffer contents, in-flight flag and transfer count.
  always_comb begin
    state_d    = state_q;
    buf0_d     = buf0_q;
    buf1_d     = buf1_q;
    inflight_d = rd;
    xfer_d     = xfer_q + {{(CNTW-1){1'b0}}, pop};
    case (state_q)
      OCC_EMPTY: begin
        if (capture) begin
          buf0_d  = bus.fifo_data;
          state_d = OCC_ONE;
        end
      end
      OCC_ONE: begin
        case ({capture, pop})
          2'b11: buf0_d = bus.fifo_data;        // replace the departing word
          2'b10: begin
            buf1_d  = bus.fifo_data;
            state_d = OCC_TWO;
          end
          2'b01: state_d = OCC_EMPTY;
          default: ;
        endcase
      end
      OCC_TWO: begin
        // The read gating never lets a capture arrive here without a pop.
        if (pop) begin
          buf0_d = buf1_q;
          if (capture) begin
            buf1_d = bus.fifo_data;
          end else begin
            state_d = OCC_ONE;
          end
        end
      end
      default: state_d = OCC_EMPTY;
    endcase
  end

  // Control state: reset drops held words, the pending capture and the count.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state_q    <= OCC_EMPTY;
      inflight_q <= 1'b0;
      xfer_q     <= '0;
    end else begin
      state_q    <= state_d;
      inflight_q <= inflight_d;
      xfer_q     <= xfer_d;
    end
  end

  // Data slots: their contents only matter when occupancy says they are valid.
  always_ff @(posedge clk_i) begin
    buf0_q <= buf0_d;
    buf1_q <= buf1_d;
  end

  assign bus.fifo_read = rd;
  assign bus.m_valid   = (state_q != OCC_EMPTY);
  assign bus.m_data    = buf0_q;
  assign xfer_count_o  = xfer_q;
  assign idle_o        = (state_q == OCC_EMPTY) && !inflight_q;
  assign occ_state_o   = state_q;

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Directed bench for fifo_stream_reader: FIFO model, stream scoreboard,
// hold-stability and read-while-empty monitors, plus a CNTW=4 twin for wrap.
module tb_fifo_stream_reader;

  localparam int WIDTH = 8;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             enable;
  logic [15:0]      xfer_count;
  logic             idle;
  logic [1:0]       occ_state;
  logic [3:0]       xfer_count_w;
  logic             idle_w;
  logic [1:0]       occ_state_w;

  int               checks = 0;
  int               errors = 0;
  int               rd_cnt = 0;
  logic [WIDTH-1:0] exp_q[$];
  logic [WIDTH-1:0] fifo_q[$];
  logic             stall_q = 1'b0;
  logic [WIDTH-1:0] stall_data = '0;

  fifo_stream_reader_if #(.WIDTH(WIDTH)) bus ();
  fifo_stream_reader_if #(.WIDTH(WIDTH)) bus_w ();

  fifo_stream_reader #(.WIDTH(WIDTH), .CNTW(16)) dut (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .enable_i     (enable),
    .bus          (bus),
    .xfer_count_o (xfer_count),
    .idle_o       (idle),
    .occ_state_o  (occ_state)
  );

  // Twin with a 4-bit counter fed the same inputs; it behaves identically.
  fifo_stream_reader #(.WIDTH(WIDTH), .CNTW(4)) dut_w (
    .clk_i        (clk),
    .rst_n_i      (rst_n),
    .enable_i     (enable),
    .bus          (bus_w),
    .xfer_count_o (xfer_count_w),
    .idle_o       (idle_w),
    .occ_state_o  (occ_state_w)
  );

  assign bus_w.fifo_empty = bus.fifo_empty;
  assign bus_w.fifo_data  = bus.fifo_data;
  assign bus_w.m_ready    = bus.m_ready;

  // clock
  always #5 clk = ~clk;

  // FIFO model: data one cycle after the strobe, registered empty flag.
  always @(posedge clk) begin
    if (bus.fifo_read && fifo_q.size() != 0) bus.fifo_data <= fifo_q.pop_front();
    bus.fifo_empty <= (fifo_q.size() == 0);
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  // Monitors: scoreboard, hold stability, strobe legality.
  always @(negedge clk) begin
    if (rst_n) begin
      if (bus.fifo_read) begin
        rd_cnt++;
        check("rd_while_empty", {31'b0, bus.fifo_empty}, 32'd0);
      end
      if (stall_q) begin
        check("hold_valid", {31'b0, bus.m_valid}, 32'd1);
        check("hold_data", {24'b0, bus.m_data}, {24'b0, stall_data});
      end
      if (bus.m_valid && bus.m_ready) begin
        if (exp_q.size() == 0) check("unexpected_word", {24'b0, bus.m_data}, 32'hFFFF_FFFF);
        else check("pop_data", {24'b0, bus.m_data}, {24'b0, exp_q.pop_front()});
      end
      stall_q    = bus.m_valid && !bus.m_ready;
      stall_data = bus.m_data;
    end else begin
      stall_q = 1'b0;
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst_n       = 1'b0;
    enable      = 1'b0;
    bus.m_ready = 1'b0;
    fifo_q.delete();
    exp_q.delete();
    tick();
    tick();
    check("rst_valid", {31'b0, bus.m_valid}, 32'd0);
    check("rst_read", {31'b0, bus.fifo_read}, 32'd0);
    check("rst_idle", {31'b0, idle}, 32'd1);
    check("rst_xfer", {16'b0, xfer_count}, 32'd0);
    rst_n = 1'b1;
  endtask

  task automatic load(input logic [WIDTH-1:0] base, input int n);
    for (int i = 0; i < n; i++) begin
      fifo_q.push_back(base + WIDTH'(i));
      exp_q.push_back(base + WIDTH'(i));
    end
  endtask

  task automatic wait_idle(input string tag, input int bound);
    logic done;
    done = 1'b0;
    for (int i = 0; i < bound && !done; i++) begin
      tick();
      if (idle && exp_q.size() == 0) done = 1'b1;
    end
    check(tag, {31'b0, done}, 32'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0;
    rst_n       = 1'b0;
    enable      = 1'b0;
    bus.m_ready = 1'b0;
    do_reset();

    // single word
    fifo_q.push_back(8'hA5);
    exp_q.push_back(8'hA5);
    enable = 1'b1; bus.m_ready = 1'b1; r0 = rd_cnt;
    tick();
    check("t1_read", {31'b0, bus.fifo_read}, 32'd1);
    check("t1_valid_t0", {31'b0, bus.m_valid}, 32'd0);
    tick();
    check("t1_read_off", {31'b0, bus.fifo_read}, 32'd0);
    check("t1_valid_t1", {31'b0, bus.m_valid}, 32'd0);
    tick();
    check("t1_valid_t2", {31'b0, bus.m_valid}, 32'd1);
    check("t1_data", {24'b0, bus.m_data}, 32'hA5);
    tick();
    check("t1_xfer", {16'b0, xfer_count}, 32'd1);
    check("t1_idle", {31'b0, idle}, 32'd1);
    check("t1_reads", rd_cnt - r0, 32'd1);

    // streaming 0x01..0x10
    do_reset();
    load(8'h01, 16);
    enable = 1'b1; bus.m_ready = 1'b1; r0 = rd_cnt;
    tick();
    check("t2_read", {31'b0, bus.fifo_read}, 32'd1);
    tick();
    check("t2_valid_t1", {31'b0, bus.m_valid}, 32'd0);
    for (int i = 0; i < 16; i++) begin
      tick();
      check("t2_valid", {31'b0, bus.m_valid}, 32'd1);
      check("t2_data", {24'b0, bus.m_data}, i + 1);
    end
    tick();
    check("t2_xfer", {16'b0, xfer_count}, 32'd16);
    check("t2_xfer_w", {28'b0, xfer_count_w}, 32'd0);
    check("t2_idle", {31'b0, idle}, 32'd1);
    check("t2_reads", rd_cnt - r0, 32'd16);

    // backpressure with 8 queued
    do_reset();
    load(8'h01, 8);
    enable = 1'b1; bus.m_ready = 1'b0; r0 = rd_cnt;
    repeat (6) tick();
    check("t3_reads_stalled", rd_cnt - r0, 32'd2);
    check("t3_valid", {31'b0, bus.m_valid}, 32'd1);
    check("t3_data", {24'b0, bus.m_data}, 32'h01);
    check("t3_occ", {30'b0, occ_state}, 32'd2);
    check("t3_read_off", {31'b0, bus.fifo_read}, 32'd0);
    bus.m_ready = 1'b1;
    wait_idle("t3_drain", 40);
    check("t3_xfer", {16'b0, xfer_count}, 32'd8);
    check("t3_reads", rd_cnt - r0, 32'd8);

    // enable drop right after a read strobe
    do_reset();
    fifo_q.push_back(8'h31); fifo_q.push_back(8'h32); fifo_q.push_back(8'h33);
    exp_q.push_back(8'h31);
    enable = 1'b1; bus.m_ready = 1'b1; r0 = rd_cnt;
    tick();
    check("t4_read", {31'b0, bus.fifo_read}, 32'd1);
    tick();
    enable = 1'b0;
    #1;
    check("t4_read_off", {31'b0, bus.fifo_read}, 32'd0);
    wait_idle("t4_drain", 20);
    repeat (3) tick();
    check("t4_no_more_reads", {31'b0, bus.fifo_read}, 32'd0);
    check("t4_reads", rd_cnt - r0, 32'd1);
    check("t4_xfer", {16'b0, xfer_count}, 32'd1);
    check("t4_idle", {31'b0, idle}, 32'd1);

    // reset mid-stream with a word held and a read in flight
    do_reset();
    for (int i = 0; i < 8; i++) fifo_q.push_back(8'h41 + 8'(i));
    exp_q.push_back(8'h41);
    enable = 1'b1; bus.m_ready = 1'b1;
    repeat (4) tick();
    check("t5_occ", {30'b0, occ_state}, 32'd1);
    check("t5_busy", {31'b0, idle}, 32'd0);
    check("t5_data", {24'b0, bus.m_data}, 32'h42);
    rst_n = 1'b0; bus.m_ready = 1'b0; enable = 1'b0;
    tick();
    rst_n = 1'b1;
    check("t5_valid", {31'b0, bus.m_valid}, 32'd0);
    check("t5_xfer", {16'b0, xfer_count}, 32'd0);
    check("t5_idle", {31'b0, idle}, 32'd1);
    bus.m_ready = 1'b1;
    repeat (4) tick();
    check("t5_stay_empty", {31'b0, bus.m_valid}, 32'd0);
    check("t5_sb_empty", exp_q.size(), 32'd0);

    // counter wrap on the 4-bit twin
    do_reset();
    load(8'h50, 17);
    enable = 1'b1; bus.m_ready = 1'b1;
    tick();
    wait_idle("t6_drain", 60);
    check("t6_xfer", {16'b0, xfer_count}, 32'd17);
    check("t6_xfer_wrap", {28'b0, xfer_count_w}, 32'd1);

    check("final_sb_empty", exp_q.size(), 32'd0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
